// File: rtl/controlpath_pkg.sv
// Shared widths, MIR field positions and the micro-address type for the Mic-1 microsequencer.
package controlpath_pkg;

  localparam int MPC_W = 9;
  localparam int MBR_W = MPC_W - 1;

  localparam int NEXT_ADDR_MSB = 35;
  localparam int NEXT_ADDR_LSB = 27;
  localparam int JUMP_BIT      = 26;
  localparam int JUMPN_BIT     = 25;
  localparam int JUMPZ_BIT     = 24;

  typedef logic [MPC_W-1:0] maddr_t;

endpackage

// File: rtl/controlpath_next_addr.sv
// Combinational next-address select: conditional high bit plus optional MBR multiway OR.
module controlpath_next_addr
  import controlpath_pkg::*;
(
  input  logic [NEXT_ADDR_MSB:JUMPZ_BIT] mir,
  input  logic                           n_flag,
  input  logic                           z_flag,
  input  logic [MBR_W-1:0]               mbr,
  output maddr_t                         next_mpc
);

  maddr_t next_addr;
  logic   jump;
  logic   jump_n;
  logic   jump_z;
  logic   high_bit;

  assign next_addr = mir[NEXT_ADDR_MSB:NEXT_ADDR_LSB];
  assign jump      = mir[JUMP_BIT];
  assign jump_n    = mir[JUMPN_BIT];
  assign jump_z    = mir[JUMPZ_BIT];

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    high_bit = (jump_z & z_flag) | (jump_n & n_flag) | next_addr[MPC_W-1];
    next_mpc = {high_bit, next_addr[MBR_W-1:0] | (jump ? {MBR_W{1'b0}} : mbr)};
  end

endmodule

// File: rtl/controlpath.sv
// Mic-1 microsequencer top: MPC register plus (by default) one-cycle N/Z flag registers.
// Define CONTROLPATH_FLAG_BYPASS_EN to drop the flag registers and use live N/Z.
module controlpath
  import controlpath_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           N,
  input  logic                           Z,
  input  logic [MBR_W-1:0]               MBR,
  input  logic [NEXT_ADDR_MSB:JUMPZ_BIT] MIR,
  output maddr_t                         MPC
);

  logic   n_use;
  logic   z_use;
  maddr_t next_mpc;

`ifdef CONTROLPATH_FLAG_BYPASS_EN
  assign n_use = N;
  assign z_use = Z;
`else
  logic n_s;
  logic z_s;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_s <= 1'b0;
      z_s <= 1'b0;
    end else begin
      n_s <= N;
      z_s <= Z;
    end
  end

  assign n_use = n_s;
  assign z_use = z_s;
`endif

  controlpath_next_addr u_next_addr (
    .mir      (MIR),
    .n_flag   (n_use),
    .z_flag   (z_use),
    .mbr      (MBR),
    .next_mpc (next_mpc)
  );

  // No stall: MPC advances on every non-reset edge.
  always_ff @(posedge clk) begin
    if (rst) MPC <= '0;
    else     MPC <= next_mpc;
  end

endmodule

// File: tb/tb_controlpath.sv
// Scoreboard bench for controlpath: stimulus pushes expected MPC values, a monitor pops and compares.
module tb_controlpath;

  logic        clk = 1'b0;
  logic        rst;
  logic        N;
  logic        Z;
  logic [7:0]  MBR;
  logic [11:0] MIR;
  logic [8:0]  MPC;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic       flag_n_prev = 1'b0;
  logic       flag_z_prev = 1'b0;

`ifdef CONTROLPATH_FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  controlpath dut (
    .clk (clk),
    .rst (rst),
    .N   (N),
    .Z   (Z),
    .MBR (MBR),
    .MIR (MIR),
    .MPC (MPC)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: address chosen from MIR/MBR, high bit from whichever flags the build sees.
  function automatic logic [8:0] model(input logic [8:0] na, input logic jump, input logic jn,
                                       input logic jz, input logic [7:0] mbr,
                                       input logic fn, input logic fz);
    logic       high;
    logic [7:0] low;
    high = (jz && fz) || (jn && fn) || na[8];
    low  = jump ? na[7:0] : (na[7:0] | mbr);
    return {high, low};
  endfunction

  // Drives one vector, records the expected MPC after the coming edge, returns at the next negedge.
  task automatic apply(input logic r, input logic n, input logic z, input logic [7:0] mbr,
                       input logic [8:0] na, input logic jump, input logic jn, input logic jz);
    logic fn;
    logic fz;
    rst = r;
    N   = n;
    Z   = z;
    MBR = mbr;
    MIR = {na, jump, jn, jz};
    fn  = BYPASS ? n : flag_n_prev;
    fz  = BYPASS ? z : flag_z_prev;
    if (r) exp_q.push_back(9'h000);
    else   exp_q.push_back(model(na, jump, jn, jz, mbr, fn, fz));
    flag_n_prev = r ? 1'b0 : n;
    flag_z_prev = r ? 1'b0 : z;
    @(negedge clk);
  endtask

  // Monitor: one result per edge whenever an expectation is pending.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("scoreboard_mpc", MPC, exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);

    apply(1'b1, 1'b1, 1'b1, 8'hA7, 9'h1C3, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b0, 1'b1, 8'h3C, 9'h0FF, 1'b1, 1'b1, 1'b0);
    check("reset_mpc", MPC, 9'h000);

    apply(1'b0, 1'b0, 1'b0, 8'h00, 9'h1FF, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 8'h00, 9'h1FF, 1'b1, 1'b0, 1'b0);
    check("direct_jump", MPC, 9'h1FF);

    apply(1'b0, 1'b1, 1'b0, 8'h00, 9'h000, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 8'h00, 9'h000, 1'b1, 1'b1, 1'b0);
    check("n_branch_taken", MPC, 9'h100);
    apply(1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 1'b1, 1'b1, 1'b0);
    check("n_branch_not_taken", MPC, 9'h000);

    apply(1'b0, 1'b0, 1'b0, 8'h55, 9'h0F0, 1'b0, 1'b0, 1'b0);
    check("mbr_multiway", MPC, 9'h0F5);

    apply(1'b0, 1'b0, 1'b1, 8'h55, 9'h0F0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 8'h55, 9'h0F0, 1'b0, 1'b0, 1'b1);
    check("z_branch_mbr", MPC, 9'h1F5);

    // Flag latency: drop Z then raise it and watch MPC[8] edge by edge.
    apply(1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 1'b1, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 1'b1, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 8'h00, 9'h000, 1'b1, 1'b0, 1'b1);
    check("z_latency_edge1", {8'h00, MPC[8]}, {8'h00, BYPASS});
    apply(1'b0, 1'b0, 1'b1, 8'h00, 9'h000, 1'b1, 1'b0, 1'b1);
    check("z_latency_edge2", {8'h00, MPC[8]}, 9'h001);

    // next_addr[8] forces the high bit whatever the flags say.
    apply(1'b0, 1'b0, 1'b0, 8'h00, 9'h123, 1'b1, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 8'h00, 9'h123, 1'b1, 1'b1, 1'b1);
    check("force_high_bit", MPC, 9'h123);

    // Mid-operation reset discards the computed address and clears the flags.
    apply(1'b0, 1'b1, 1'b1, 8'hFF, 9'h1AA, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 1'b1, 8'hFF, 9'h1AA, 1'b0, 1'b1, 1'b1);
    check("mid_reset", MPC, 9'h000);

    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom), 8'($urandom),
            9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    check("queue_drained", 9'(exp_q.size()), 9'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
